// File: rtl/fifo_pkg.sv
// Shared FIFO types and elaboration helpers for the single- and dual-clock FIFOs.
// Latency: none, declarations and constant functions only.
// Backpressure: not applicable.
package fifo_pkg;

  // Prefetch state of the FWFT output register.
  typedef enum logic {
    ST_IDLE = 1'b0,  // output register empty
    ST_HOLD = 1'b1   // output register holds the head word
  } fwft_state_e;

  // Width of pointers and occupancy count: one extra bit for the wrap.
  function automatic int fifo_count_w(input int addr_width);
    return addr_width + 1;
  endfunction

  // Legal thresholds: prog_full in 1..DEPTH, prog_empty in 0..DEPTH-1.
  function automatic bit fifo_thresh_ok(input int addr_width, input int pf, input int pe);
    int depth;
    depth = 1 << addr_width;
    return (pf >= 1) && (pf <= depth) && (pe >= 0) && (pe <= depth - 1);
  endfunction

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port RAM, one write port and one registered read port.
// Latency: read data valid one cycle after rd_en_i; write visible next cycle.
// Backpressure: none, the caller guarantees address safety.
module sdp_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en_i,
  input  logic [ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_dat_i,
  input  logic                  rd_en_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  output logic [DATA_WIDTH-1:0] rd_dat_o
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rd_dat_q;

  // Storage array: written on request, deliberately never reset.
  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_dat_i;
  end

  // Read register: holds its value until the next read, cleared on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          rd_dat_q <= '0;
    else if (rd_en_i) rd_dat_q <= mem_q[rd_addr_i];
  end

  assign rd_dat_o = rd_dat_q;

endmodule

// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO, standard or FWFT read, programmable levels, occupancy count.
// Latency: standard read 1 cycle; FWFT head visible 1 cycle after write into empty.
// Backpressure: writes refused while full (overflow), reads refused while empty (underflow).
module sync_fifo_prog
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH        = 8,
  parameter int ADDR_WIDTH        = 4,
  parameter int FWFT_EN           = 1,
  parameter int PROG_FULL_THRESH  = 12,
  parameter int PROG_EMPTY_THRESH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  wr_en,
  output logic                  full,
  output logic                  almost_full,
  output logic                  prog_full,
  output logic                  wr_ack,
  output logic                  overflow,
  output logic [DATA_WIDTH-1:0] dout,
  input  logic                  rd_en,
  output logic                  empty,
  output logic                  almost_empty,
  output logic                  prog_empty,
  output logic                  valid,
  output logic                  underflow,
  output logic [ADDR_WIDTH:0]   data_count
);

  localparam int CW    = fifo_count_w(ADDR_WIDTH);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [CW-1:0] FULL_C  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C = CW'(DEPTH - 1);
  localparam logic [CW-1:0] PF_C    = CW'(PROG_FULL_THRESH);
  localparam logic [CW-1:0] PE_C    = CW'(PROG_EMPTY_THRESH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  if (!fifo_thresh_ok(ADDR_WIDTH, PROG_FULL_THRESH, PROG_EMPTY_THRESH)) begin : g_bad_thresh
    $fatal(1, "sync_fifo_prog: programmable threshold out of range");
  end

  logic [CW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, cnt_q, cnt_d;
  logic          wr_acc, rd_acc, ram_rd, ram_empty, empty_d, valid_d;
  fwft_state_e   state_q, state_d;
  logic          full_q, afull_q, pfull_q, empty_q, aempty_q, pempty_q;
  logic          valid_q, ack_q, ovf_q, udf_q;
  logic [DATA_WIDTH-1:0] ram_dat;

  // RAM holds nothing readable when the pointers match, MSB included;
  // an MSB-only difference means the RAM is completely full instead.
  assign ram_empty = (wr_ptr_q == rd_ptr_q);

  // Accept against the registered flags and advance write side and count.
  always_comb begin
    wr_acc   = wr_en && !full_q;
    rd_acc   = rd_en && !empty_q;
    wr_ptr_d = wr_ptr_q + {{(CW-1){1'b0}}, wr_acc};
    cnt_d    = cnt_q + {{(CW-1){1'b0}}, wr_acc} - {{(CW-1){1'b0}}, rd_acc};
  end

  // Prefetch FSM next state and RAM read request; standard mode reads directly.
  always_comb begin
    state_d = state_q;
    ram_rd  = 1'b0;
    if (FWFT_EN != 0) begin
      case (state_q)
        ST_IDLE: begin
          if (!ram_empty) begin
            ram_rd  = 1'b1;
            state_d = ST_HOLD;
          end
        end
        ST_HOLD: begin
          // Popping the head: refill from RAM with no bubble, or fall idle.
          if (rd_acc) begin
            if (!ram_empty) ram_rd  = 1'b1;
            else            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else begin
      ram_rd = rd_acc;
    end
    rd_ptr_d = rd_ptr_q + {{(CW-1){1'b0}}, ram_rd};
    empty_d  = (FWFT_EN != 0) ? (state_d != ST_HOLD) : (cnt_d == '0);
    valid_d  = (FWFT_EN != 0) ? (state_d == ST_HOLD) : rd_acc;
  end

  // Pointers, count, FSM and all status flags registered together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      state_q  <= ST_IDLE;
      full_q   <= 1'b0;
      afull_q  <= 1'b0;
      pfull_q  <= 1'b0;
      empty_q  <= 1'b1;
      aempty_q <= 1'b1;
      pempty_q <= 1'b1;
      valid_q  <= 1'b0;
      ack_q    <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
      full_q   <= (cnt_d == FULL_C);
      afull_q  <= (cnt_d >= AFULL_C);
      pfull_q  <= (cnt_d >= PF_C);
      empty_q  <= empty_d;
      aempty_q <= (cnt_d <= ONE_C);
      pempty_q <= (cnt_d <= PE_C);
      valid_q  <= valid_d;
      ack_q    <= wr_acc;
      ovf_q    <= wr_en && full_q;
      udf_q    <= rd_en && empty_q;
    end
  end

  sdp_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk      (clk),
    .rst      (rst),
    .wr_en_i  (wr_acc),
    .wr_addr_i(wr_ptr_q[ADDR_WIDTH-1:0]),
    .wr_dat_i (din),
    .rd_en_i  (ram_rd),
    .rd_addr_i(rd_ptr_q[ADDR_WIDTH-1:0]),
    .rd_dat_o (ram_dat)
  );

  assign full         = full_q;
  assign almost_full  = afull_q;
  assign prog_full    = pfull_q;
  assign wr_ack       = ack_q;
  assign overflow     = ovf_q;
  assign dout         = ram_dat;
  assign empty        = empty_q;
  assign almost_empty = aempty_q;
  assign prog_empty   = pempty_q;
  assign valid        = valid_q;
  assign underflow    = udf_q;
  assign data_count   = cnt_q;

endmodule

// File: doc/sync_fifo_prog.md
# sync_fifo_prog

Single-clock FIFO with parametrised width and depth, a standard or first-word-fall-through (FWFT) read mode, programmable full/empty thresholds, an occupancy count and per-port status pulses. It is the single-clock-domain successor to the team's dual-clock FIFO. It buffers streams between blocks sharing one clock, where the consumer needs level information for burst scheduling.

## Interface
Parameters:
- DATA_WIDTH, 8, word width in bits (≥1)
- ADDR_WIDTH, 4, log2 of depth; DEPTH = 2**ADDR_WIDTH (≥2)
- FWFT_EN, 1, 1 = FWFT read mode, 0 = standard read mode
- PROG_FULL_THRESH, 12, prog_full asserts when count ≥ this; legal range 1..DEPTH
- PROG_EMPTY_THRESH, 2, prog_empty asserts when count ≤ this; legal range 0..DEPTH-1

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  reset, asynchronous and active-high
- din  in  DATA_WIDTH  write data
- wr_en  in  1  write request
- full  out  1  count == DEPTH
- almost_full  out  1  count ≥ DEPTH-1
- prog_full  out  1  count ≥ PROG_FULL_THRESH
- wr_ack  out  1  one-cycle pulse, previous write accepted
- overflow  out  1  one-cycle pulse, previous write rejected (full)
- dout  out  DATA_WIDTH  read data
- rd_en  in  1  read request (FWFT: pop/acknowledge head word)
- empty  out  1  no word readable
- almost_empty  out  1  count ≤ 1
- prog_empty  out  1  count ≤ PROG_EMPTY_THRESH
- valid  out  1  dout holds a valid word
- underflow  out  1  one-cycle pulse, previous read rejected (empty)
- data_count  out  ADDR_WIDTH+1  words held, including the FWFT output register

## Operation
- Capacity is exactly DEPTH words in both modes. In FWFT mode the output register counts toward DEPTH.
- Pointers are ADDR_WIDTH+1 bits. They wrap modulo 2*DEPTH. Full/empty are resolved from the MSB.
- Acceptance at an edge uses the flag values present before that edge:
  - A write is accepted iff wr_en && !full.
  - A read is accepted iff rd_en && !empty.
- Simultaneous read and write:
  - When full: the read is accepted and the write is rejected (overflow).
  - When empty: the write is accepted and the read is rejected (underflow).
  - Otherwise both are accepted and count is unchanged.
- Standard mode: valid pulses one cycle per accepted read. dout holds its last value otherwise.
- FWFT mode: a prefetch state machine has two states, IDLE (output register empty) and HOLD (output register valid).
  - IDLE→HOLD: RAM non-empty, one prefetch cycle.
  - HOLD→IDLE: a read is accepted and the RAM is empty.
  - HOLD stays in HOLD: a read is accepted and the RAM is non-empty. The next word is loaded with no bubble.
  - valid = !empty = (state == HOLD).
- All status outputs are registered.
- Thresholds are checked at elaboration. An out-of-range value is a fatal elaboration error.
- Reset mid-operation clears all contents immediately. Data in flight is discarded.

## Timing
- Reset values:
  - Pointers and data_count: 0.
  - empty, almost_empty, prog_empty: 1 (prog_empty is 1 for any legal threshold).
  - full, almost_full, prog_full: 0.
  - dout, valid, wr_ack, overflow, underflow: 0.
  - FWFT state: IDLE.
- Write into an empty FIFO at edge N:
  - data_count = 1 after edge N.
  - Standard mode: empty falls after edge N.
  - FWFT mode: empty falls and dout is valid after edge N+1.
- Standard read accepted at edge N: dout is updated and valid = 1 after edge N (latency 1).
- FWFT read accepted at edge N: the next word appears on dout after edge N, or empty rises after edge N if no word remains.
- wr_ack, overflow and underflow are asserted for exactly the cycle after the edge that evaluated the request.
- data_count and all level flags update in the cycle after the accepting edge. In FWFT mode data_count may read 1 while empty is still 1 during the prefetch cycle.
- Sustained throughput is one write and one read per cycle.

## Structure
- Shared package fifo_pkg:
  - the FWFT state enum (IDLE, HOLD);
  - a function fifo_count_w(addr_width) returning ADDR_WIDTH+1;
  - the threshold range-check function, shared with the dual-clock FIFO.
- One sub-module, sdp_ram: simple dual-port RAM with registered read, DATA_WIDTH × DEPTH, with no reset on the storage array.
- Pointer logic, counting, flag logic and the FWFT state machine live in sync_fifo_prog.

## Test plan
Default parameters unless stated.
- Reset release: all outputs match the reset values above; data_count = 0; no pulses for 5 cycles with idle inputs.
- FWFT single word: write 0xA5 at edge N → dout = 0xA5, valid = 1, empty = 0 after edge N+1; rd_en for 1 cycle → empty = 1, data_count = 0.
- Fill to full: write 0x00..0x0F over 16 cycles →
  - prog_full after the 12th write;
  - almost_full after the 15th write;
  - full after the 16th write;
  - a 17th write (0x10) gives overflow = 1, wr_ack = 0, data_count = 16.
- Drain with wrap: read all 16 words → order 0x00..0x0F; prog_empty at count ≤ 2; a 17th read gives underflow = 1.
- Simultaneous read/write: at full, both requested → read of 0x00 accepted, write rejected, data_count = 15. At count 8, both requested for 100 cycles → data_count stays 8 and ordering is preserved.
- FWFT_EN = 0, PROG_FULL_THRESH = 4: write 0x11, read at edge N → dout = 0x11 and valid = 1 only in the cycle after edge N; prog_full at count 4; assert rst mid-burst → empty = 1, data_count = 0 asynchronously.
